// File: rtl/mmio_uart_hub_pkg.sv
// mmio_uart_hub_pkg: shared address map, register offsets, STATUS layout and
// the address decoder used by the MMIO UART hub.
package mmio_uart_hub_pkg;

  // Upper address nibble that selects the hub
  localparam logic [3:0]  MMIO_REGION    = 4'h8;
  localparam int unsigned CH_IDX_W       = 3;

  // Per-channel register offsets (channel c at base + c*0x100)
  localparam logic [7:0]  OFF_STATUS     = 8'h00;
  localparam logic [7:0]  OFF_RXDATA     = 8'h04;
  localparam logic [7:0]  OFF_TXDATA     = 8'h08;
  localparam logic [7:0]  OFF_CTRL       = 8'h0C;

  // CTRL bit positions
  localparam int unsigned CTRL_IRQ_EN    = 0;
  localparam int unsigned CTRL_CLR_STICK = 1;

  // Counter block, relative to the region base
  localparam logic [27:0] CNT_CYCLE      = 28'h000_F000;
  localparam logic [27:0] CNT_INSTRET    = 28'h000_F004;
  localparam logic [27:0] CNT_CLEAR      = 28'h000_F008;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  rx_count;
    logic [3:0]  rsvd_lo;
    logic        tx_drop;
    logic        rx_overflow;
    logic        rx_not_empty;
    logic        tx_not_full;
  } status_t;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_STATUS,
    REG_RXDATA,
    REG_TXDATA,
    REG_CTRL,
    REG_CYCLE,
    REG_INSTRET,
    REG_CNTCLR
  } reg_e;

  // Channel registers live where addr[27:11] is zero, so the counter page
  // at 0xF000 can never alias channel 0.
  function automatic reg_e decode_reg(input logic [31:0] addr);
    decode_reg = REG_NONE;
    if (addr[31:28] == MMIO_REGION) begin
      if (addr[27:11] == 17'd0) begin
        case (addr[7:0])
          OFF_STATUS: decode_reg = REG_STATUS;
          OFF_RXDATA: decode_reg = REG_RXDATA;
          OFF_TXDATA: decode_reg = REG_TXDATA;
          OFF_CTRL:   decode_reg = REG_CTRL;
          default:    decode_reg = REG_NONE;
        endcase
      end else if (addr[27:0] == CNT_CYCLE) begin
        decode_reg = REG_CYCLE;
      end else if (addr[27:0] == CNT_INSTRET) begin
        decode_reg = REG_INSTRET;
      end else if (addr[27:0] == CNT_CLEAR) begin
        decode_reg = REG_CNTCLR;
      end
    end
  endfunction

endpackage

// File: rtl/mmio_uart_hub_if.sv
// mmio_uart_hub_if: CPU data-port bus plus per-channel UART byte streams.
//   slave  : the hub (consumes CPU strobes, drives read data and TX bytes)
//   master : CPU / serialiser side
interface mmio_uart_hub_if #(
  parameter int unsigned NUM_CH = 2
);
  logic                  stall;
  logic [31:0]           io_addr;
  logic                  io_re;
  logic [3:0]            io_we;
  logic [31:0]           io_din;
  logic [31:0]           io_dout;
  logic                  io_hit;
  logic                  inst_ret;
  logic                  irq;
  logic [8*NUM_CH-1:0]   tx_data;
  logic [NUM_CH-1:0]     tx_valid;
  logic [NUM_CH-1:0]     tx_ready;
  logic [8*NUM_CH-1:0]   rx_data;
  logic [NUM_CH-1:0]     rx_valid;

  modport slave (
    input  stall, io_addr, io_re, io_we, io_din, inst_ret, tx_ready, rx_data, rx_valid,
    output io_dout, io_hit, irq, tx_data, tx_valid
  );

  modport master (
    output stall, io_addr, io_re, io_we, io_din, inst_ret, tx_ready, rx_data, rx_valid,
    input  io_dout, io_hit, irq, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_uart_hub_io_fifo.sv
// mmio_uart_hub_io_fifo: show-ahead synchronous FIFO.
//   push/din  : write when accepted (not full, or full with a same-cycle pop)
//   pop       : remove head when not empty
//   dout      : current head
//   full, empty, count : occupancy seen before the current edge
module mmio_uart_hub_io_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH):0]         count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // A pop frees the slot, so a full FIFO still takes a push in that cycle
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; reset only discards it by clearing the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_hub.sv
// mmio_uart_hub: memory-mapped UART hub with per-channel TX/RX FIFOs and
// cycle / retired-instruction counters.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : CPU data port (addr/re/we/din -> dout/hit), inst_ret, irq,
//              per-channel tx_data/tx_valid/tx_ready and rx_data/rx_valid
module mmio_uart_hub
  import mmio_uart_hub_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mmio_uart_hub_if.slave   bus
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic                acc_en, in_region, rd_en, wr_en;
  reg_e                reg_sel;
  logic [CH_IDX_W-1:0] ch_sel;

  logic [NUM_CH-1:0]   rx_full, rx_empty, rx_pop;
  logic [NUM_CH-1:0]   tx_full, tx_empty, tx_pop, tx_push;
  logic [7:0]          rx_head  [NUM_CH];
  logic [7:0]          tx_head  [NUM_CH];
  logic [CW-1:0]       rx_count [NUM_CH];
  logic [CW-1:0]       tx_count [NUM_CH];

  logic [NUM_CH-1:0]   irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]   rx_ovf_q, rx_ovf_d;
  logic [NUM_CH-1:0]   tx_drop_q, tx_drop_d;
  logic [31:0]         cycle_q, cycle_d;
  logic [31:0]         instret_q, instret_d;
  logic [31:0]         io_dout_q, io_dout_d;
  logic                io_hit_q, io_hit_d;
  logic [31:0]         rd_data_c;
  logic                cnt_clr;
  status_t             status;
  logic                unused_din;

  // Access qualification: stall masks both strobes
  assign acc_en    = ~bus.stall;
  assign in_region = (bus.io_addr[31:28] == MMIO_REGION);
  assign rd_en     = bus.io_re & acc_en & in_region;
  assign wr_en     = (|bus.io_we) & acc_en & in_region;
  assign reg_sel   = decode_reg(bus.io_addr);
  assign ch_sel    = bus.io_addr[10:8];
  assign cnt_clr   = wr_en & (reg_sel == REG_CNTCLR);
  assign unused_din = ^bus.io_din[31:8];

  // Per-channel FIFOs
  for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
    mmio_uart_hub_io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.rx_valid[c]),
      .pop   (rx_pop[c]),
      .din   (bus.rx_data[8*c +: 8]),
      .dout  (rx_head[c]),
      .full  (rx_full[c]),
      .empty (rx_empty[c]),
      .count (rx_count[c])
    );

    mmio_uart_hub_io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push[c]),
      .pop   (tx_pop[c]),
      .din   (bus.io_din[7:0]),
      .dout  (tx_head[c]),
      .full  (tx_full[c]),
      .empty (tx_empty[c]),
      .count (tx_count[c])
    );

    logic unused_tx_count;
    assign unused_tx_count   = ^tx_count[c];
    assign bus.tx_data[8*c +: 8] = tx_head[c];
  end

  assign bus.tx_valid = ~tx_empty;
  assign bus.irq      = |(irq_en_q & ~rx_empty);
  assign bus.io_dout  = io_dout_q;
  assign bus.io_hit   = io_hit_q;

  // Channel control: FIFO strobes, CTRL writes and sticky error bits.
  // A sticky clear and a new error in the same cycle leaves the bit set.
  always_comb begin
    rx_pop    = '0;
    tx_push   = '0;
    tx_pop    = '0;
    irq_en_d  = irq_en_q;
    rx_ovf_d  = rx_ovf_q;
    tx_drop_d = tx_drop_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_sel == 3'(c)) begin
        rx_pop[c] = rd_en && (reg_sel == REG_RXDATA);
        // Full is sampled pre-edge: a same-cycle drain does not make room
        if (wr_en && (reg_sel == REG_TXDATA)) begin
          if (tx_full[c]) tx_drop_d[c] = 1'b1;
          else            tx_push[c]   = 1'b1;
        end
        if (wr_en && (reg_sel == REG_CTRL)) begin
          irq_en_d[c] = bus.io_din[CTRL_IRQ_EN];
          if (bus.io_din[CTRL_CLR_STICK]) begin
            rx_ovf_d[c]  = 1'b0;
            if (!(tx_full[c] && reg_sel == REG_TXDATA)) tx_drop_d[c] = 1'b0;
          end
        end
      end
      if (bus.rx_valid[c] && rx_full[c] && !rx_pop[c]) rx_ovf_d[c] = 1'b1;
      tx_pop[c] = bus.tx_ready[c] & ~tx_empty[c];
    end
  end

  // Counters: a clear wins over the increment of the same cycle
  always_comb begin
    cycle_d   = cnt_clr ? 32'd0 : cycle_q + 32'd1;
    instret_d = cnt_clr ? 32'd0 : instret_q + 32'(bus.inst_ret);
  end

  // Read mux over pre-edge state
  always_comb begin
    rd_data_c = '0;
    status    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_sel == 3'(c)) begin
        status.rx_count     = (32'(rx_count[c]) > 32'd255) ? 8'hFF : 8'(rx_count[c]);
        status.tx_drop      = tx_drop_q[c];
        status.rx_overflow  = rx_ovf_q[c];
        status.rx_not_empty = ~rx_empty[c];
        status.tx_not_full  = ~tx_full[c];
        if (reg_sel == REG_STATUS)      rd_data_c = status;
        else if (reg_sel == REG_RXDATA) rd_data_c = rx_empty[c] ? 32'd0 : {24'd0, rx_head[c]};
        else if (reg_sel == REG_CTRL)   rd_data_c = {31'd0, irq_en_q[c]};
      end
    end
    if (reg_sel == REG_CYCLE)   rd_data_c = cycle_q;
    if (reg_sel == REG_INSTRET) rd_data_c = instret_q;
  end

  // io_dout holds unless a qualified read lands in the hub
  always_comb begin
    io_dout_d = rd_en ? rd_data_c : io_dout_q;
    io_hit_d  = (bus.io_re | (|bus.io_we)) & acc_en & in_region;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_q  <= '0;
      rx_ovf_q  <= '0;
      tx_drop_q <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
      io_dout_q <= '0;
      io_hit_q  <= 1'b0;
    end else begin
      irq_en_q  <= irq_en_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_drop_q <= tx_drop_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      io_dout_q <= io_dout_d;
      io_hit_q  <= io_hit_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_hub.sv
// tb_mmio_uart_hub: directed scenarios plus a randomized run against a
// queue-based reference model of the hub.
module tb_mmio_uart_hub;
  localparam int NCH   = 2;
  localparam int DEPTH = 8;

  localparam logic [31:0] A_STATUS0 = 32'h8000_0000;
  localparam logic [31:0] A_RX0     = 32'h8000_0004;
  localparam logic [31:0] A_TX0     = 32'h8000_0008;
  localparam logic [31:0] A_CTRL0   = 32'h8000_000C;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmio_uart_hub_if #(.NUM_CH(NCH)) bus();

  mmio_uart_hub #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state
  logic [7:0] txq [NCH][$];
  logic [7:0] rxq [NCH][$];
  bit         ovf_m  [NCH];
  bit         drop_m [NCH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    bus.io_addr = a; bus.io_din = d; bus.io_we = 4'hF;
    tick();
    bus.io_we = 4'h0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    bus.io_addr = a; bus.io_re = 1'b1;
    tick();
    bus.io_re = 1'b0;
    d = bus.io_dout;
  endtask

  task automatic rx_push(input int ch, input logic [7:0] b);
    bus.rx_data[8*ch +: 8] = b; bus.rx_valid[ch] = 1'b1;
    tick();
    bus.rx_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.stall = 0; bus.io_addr = 0; bus.io_re = 0; bus.io_we = 0; bus.io_din = 0;
    bus.inst_ret = 0; bus.tx_ready = 0; bus.rx_data = 0; bus.rx_valid = 0;
    #12;
    chk_cnt++; if (bus.io_dout !== 32'd0) $display("FAIL reset_dout got %h want 0", bus.io_dout); else pass_cnt++;
    chk_cnt++; if (bus.io_hit !== 1'b0) $display("FAIL reset_hit got %b want 0", bus.io_hit); else pass_cnt++;
    chk_cnt++; if (bus.tx_valid !== 2'b00) $display("FAIL reset_tx_valid got %b want 00", bus.tx_valid); else pass_cnt++;
    chk_cnt++; if (bus.irq !== 1'b0) $display("FAIL reset_irq got %b want 0", bus.irq); else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  task automatic test_tx_basic();
    cpu_write(A_TX0, 32'h41);
    cpu_write(A_TX0, 32'h42);
    chk_cnt++; if (bus.tx_valid[0] !== 1'b1) $display("FAIL tx_basic_valid got %b want 1", bus.tx_valid[0]); else pass_cnt++;
    chk_cnt++; if (bus.tx_data[7:0] !== 8'h41) $display("FAIL tx_basic_b0 got %h want 41", bus.tx_data[7:0]); else pass_cnt++;
    bus.tx_ready[0] = 1'b1;
    tick();
    chk_cnt++; if (bus.tx_data[7:0] !== 8'h42) $display("FAIL tx_basic_b1 got %h want 42", bus.tx_data[7:0]); else pass_cnt++;
    tick();
    chk_cnt++; if (bus.tx_valid[0] !== 1'b0) $display("FAIL tx_basic_done got %b want 0", bus.tx_valid[0]); else pass_cnt++;
    bus.tx_ready[0] = 1'b0;
  endtask

  task automatic test_tx_full();
    logic [31:0] d;
    for (int i = 0; i < 9; i++) begin
      cpu_write(A_TX0, 32'(8'h10 + i));
      if (i == 7) begin
        cpu_read(A_STATUS0, d);
        chk_cnt++; if (d[0] !== 1'b0 || d[3] !== 1'b0) $display("FAIL tx_full_at8 got %h want bit0=0 bit3=0", d); else pass_cnt++;
      end
    end
    cpu_read(A_STATUS0, d);
    chk_cnt++; if (d[3] !== 1'b1 || d[0] !== 1'b0) $display("FAIL tx_drop_set got %h want bit3=1 bit0=0", d); else pass_cnt++;
    cpu_write(A_CTRL0, 32'h2);
    cpu_read(A_STATUS0, d);
    chk_cnt++; if (d[3] !== 1'b0) $display("FAIL tx_drop_clear got %h want bit3=0", d); else pass_cnt++;
    bus.tx_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (bus.tx_valid[0] !== 1'b1 || bus.tx_data[7:0] !== 8'(8'h10 + i))
        $display("FAIL tx_full_drain%0d got v=%b %h want v=1 %h", i, bus.tx_valid[0], bus.tx_data[7:0], 8'(8'h10 + i));
      else pass_cnt++;
      tick();
    end
    chk_cnt++; if (bus.tx_valid[0] !== 1'b0) $display("FAIL tx_full_empty got %b want 0", bus.tx_valid[0]); else pass_cnt++;
    bus.tx_ready[0] = 1'b0;
  endtask

  task automatic test_rx_read();
    logic [31:0] d;
    rx_push(1, 8'h5A);
    cpu_read(32'h8000_0104, d);
    chk_cnt++; if (d !== 32'h0000_005A) $display("FAIL rx_read got %h want 0000005a", d); else pass_cnt++;
    cpu_read(32'h8000_0104, d);
    chk_cnt++; if (d !== 32'd0) $display("FAIL rx_reread got %h want 0", d); else pass_cnt++;
    cpu_read(32'h8000_0100, d);
    chk_cnt++; if (d[1] !== 1'b0) $display("FAIL rx_empty_status got %h want bit1=0", d); else pass_cnt++;
  endtask

  task automatic test_rx_full_popthrough();
    logic [31:0] d;
    logic [7:0]  q[$];
    logic [7:0]  b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom); q.push_back(b); rx_push(0, b);
    end
    b = 8'($urandom);
    bus.io_addr = A_RX0; bus.io_re = 1'b1; bus.rx_data[7:0] = b; bus.rx_valid[0] = 1'b1;
    tick();
    bus.io_re = 1'b0; bus.rx_valid = '0;
    chk_cnt++; if (bus.io_dout !== {24'd0, q[0]}) $display("FAIL rx_popthrough_data got %h want %h", bus.io_dout, q[0]); else pass_cnt++;
    void'(q.pop_front()); q.push_back(b);
    cpu_read(A_STATUS0, d);
    chk_cnt++; if (d[15:8] !== 8'd8) $display("FAIL rx_popthrough_count got %0d want 8", d[15:8]); else pass_cnt++;
    chk_cnt++; if (d[2] !== 1'b0 || d[1] !== 1'b1) $display("FAIL rx_popthrough_flags got %h want ovf=0 ne=1", d); else pass_cnt++;
    rx_push(0, 8'hEE);
    cpu_read(A_STATUS0, d);
    chk_cnt++; if (d[2] !== 1'b1 || d[15:8] !== 8'd8) $display("FAIL rx_overflow got %h want ovf=1 count=8", d); else pass_cnt++;
    cpu_write(A_CTRL0, 32'h2);
    cpu_read(A_STATUS0, d);
    chk_cnt++; if (d[2] !== 1'b0) $display("FAIL rx_ovf_clear got %h want bit2=0", d); else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_read(A_RX0, d);
      chk_cnt++; if (d !== {24'd0, q[i]}) $display("FAIL rx_order%0d got %h want %h", i, d, q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    cpu_write(A_CTRL0, 32'h1);
    chk_cnt++; if (bus.irq !== 1'b0) $display("FAIL irq_idle got %b want 0", bus.irq); else pass_cnt++;
    rx_push(0, 8'h33);
    chk_cnt++; if (bus.irq !== 1'b1) $display("FAIL irq_set got %b want 1", bus.irq); else pass_cnt++;
    cpu_read(A_RX0, d);
    chk_cnt++; if (bus.irq !== 1'b0 || d !== 32'h33) $display("FAIL irq_drain got irq=%b d=%h want 0 33", bus.irq, d); else pass_cnt++;
    cpu_write(A_CTRL0, 32'h0);
    // read and write in one cycle: the read sees the pre-write CTRL
    bus.io_addr = A_CTRL0; bus.io_din = 32'h1; bus.io_re = 1'b1; bus.io_we = 4'hF;
    tick();
    bus.io_re = 1'b0; bus.io_we = 4'h0;
    chk_cnt++; if (bus.io_dout !== 32'd0) $display("FAIL rw_same_cycle got %h want 0", bus.io_dout); else pass_cnt++;
    cpu_read(A_CTRL0, d);
    chk_cnt++; if (d !== 32'd1) $display("FAIL ctrl_readback got %h want 1", d); else pass_cnt++;
    cpu_write(A_CTRL0, 32'h0);
  endtask

  task automatic test_decode();
    logic [31:0] d;
    cpu_read(32'h8000_0010, d);
    chk_cnt++; if (d !== 32'd0 || bus.io_hit !== 1'b1) $display("FAIL unmapped_off got d=%h hit=%b want 0 1", d, bus.io_hit); else pass_cnt++;
    cpu_read(32'h8000_0200, d);
    chk_cnt++; if (d !== 32'd0) $display("FAIL bad_channel got %h want 0", d); else pass_cnt++;
    cpu_write(32'h8000_0208, 32'h77);
    chk_cnt++; if (bus.tx_valid !== 2'b00) $display("FAIL bad_channel_tx got %b want 00", bus.tx_valid); else pass_cnt++;
    cpu_read(32'h0000_0004, d);
    chk_cnt++; if (bus.io_hit !== 1'b0) $display("FAIL no_hit got %b want 0", bus.io_hit); else pass_cnt++;
  endtask

  task automatic test_stall_counters();
    logic [31:0] d;
    rx_push(0, 8'hA7);
    cpu_read(A_STATUS0, d);
    chk_cnt++; if (d !== 32'h0000_0103) $display("FAIL stall_pre got %h want 00000103", d); else pass_cnt++;
    bus.stall = 1'b1; bus.io_addr = A_RX0; bus.io_re = 1'b1;
    tick(); tick();
    chk_cnt++; if (bus.io_dout !== 32'h0000_0103) $display("FAIL stall_hold got %h want 00000103", bus.io_dout); else pass_cnt++;
    bus.io_re = 1'b0; bus.stall = 1'b0;
    cpu_read(A_STATUS0, d);
    chk_cnt++; if (d !== 32'h0000_0103) $display("FAIL stall_nopop got %h want 00000103", d); else pass_cnt++;
    cpu_read(A_RX0, d);
    chk_cnt++; if (d !== 32'h0000_00A7) $display("FAIL stall_after got %h want 000000a7", d); else pass_cnt++;
    bus.inst_ret = 1'b1;
    cpu_write(32'h8000_F008, 32'h0);
    tick();
    cpu_read(32'h8000_F000, d);
    chk_cnt++; if (d !== 32'd1) $display("FAIL cycle_clear got %0d want 1", d); else pass_cnt++;
    tick();
    bus.inst_ret = 1'b0;
    cpu_read(32'h8000_F004, d);
    chk_cnt++; if (d !== 32'd3) $display("FAIL instret_count got %0d want 3", d); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    cpu_write(A_TX0, 32'h11);
    cpu_write(A_TX0, 32'h22);
    chk_cnt++; if (bus.tx_valid[0] !== 1'b1) $display("FAIL areset_pre got %b want 1", bus.tx_valid[0]); else pass_cnt++;
    #2; rst = 1'b0; #1;
    chk_cnt++; if (bus.tx_valid !== 2'b00) $display("FAIL areset_async got %b want 00", bus.tx_valid); else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    tick();
    chk_cnt++; if (bus.tx_valid !== 2'b00) $display("FAIL areset_post got %b want 00", bus.tx_valid); else pass_cnt++;
    cpu_read(A_STATUS0, d);
    chk_cnt++; if (d !== 32'h1) $display("FAIL areset_status got %h want 1", d); else pass_cnt++;
  endtask

  task automatic test_random();
    int          op, ch, tx_pre, rx_pre;
    bit          popped;
    logic [31:0] exp_rd, wd;
    logic [NCH-1:0] rxv, txr;
    logic [8*NCH-1:0] rxd;
    for (int c = 0; c < NCH; c++) begin
      txq[c].delete(); rxq[c].delete(); ovf_m[c] = 0; drop_m[c] = 0;
    end
    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(0, 4);   // 0 idle, 1 TX write, 2 RX read, 3 STATUS read, 4 CTRL clear
      ch  = $urandom_range(0, NCH - 1);
      wd  = $urandom;
      rxd = (8*NCH)'($urandom);
      for (int c = 0; c < NCH; c++) begin
        rxv[c] = ($urandom_range(0, 9) < 4);
        txr[c] = ($urandom_range(0, 9) < 3);
      end
      bus.io_addr  = 32'h8000_0000 | 32'(ch << 8) |
                     ((op == 1) ? 32'h8 : (op == 2) ? 32'h4 : (op == 4) ? 32'hC : 32'h0);
      bus.io_din   = (op == 4) ? 32'h2 : wd;
      bus.io_we    = (op == 1 || op == 4) ? 4'hF : 4'h0;
      bus.io_re    = (op == 2 || op == 3);
      bus.rx_data  = rxd;
      bus.rx_valid = rxv;
      bus.tx_ready = txr;
      // expected read value from pre-edge model state
      exp_rd = 32'd0;
      if (op == 2 && rxq[ch].size() > 0) exp_rd = {24'd0, rxq[ch][0]};
      if (op == 3) exp_rd = {16'd0, 8'(rxq[ch].size()), 4'd0, drop_m[ch], ovf_m[ch],
                             rxq[ch].size() > 0, txq[ch].size() < DEPTH};
      for (int c = 0; c < NCH; c++) begin
        tx_pre = txq[c].size();
        rx_pre = rxq[c].size();
        if (op == 4 && ch == c) begin ovf_m[c] = 0; drop_m[c] = 0; end
        if (txr[c] && tx_pre > 0) void'(txq[c].pop_front());
        if (op == 1 && ch == c) begin
          if (tx_pre < DEPTH) txq[c].push_back(wd[7:0]); else drop_m[c] = 1;
        end
        popped = (op == 2 && ch == c && rx_pre > 0);
        if (popped) void'(rxq[c].pop_front());
        if (rxv[c]) begin
          if (rx_pre < DEPTH || popped) rxq[c].push_back(rxd[8*c +: 8]); else ovf_m[c] = 1;
        end
      end
      tick();
      bus.io_re = 1'b0; bus.io_we = 4'h0; bus.rx_valid = '0;
      if (op == 2 || op == 3) begin
        chk_cnt++; if (bus.io_dout !== exp_rd) $display("FAIL rand_read n=%0d op=%0d ch=%0d got %h want %h", n, op, ch, bus.io_dout, exp_rd); else pass_cnt++;
      end
      for (int c = 0; c < NCH; c++) begin
        chk_cnt++;
        if (bus.tx_valid[c] !== (txq[c].size() > 0) ||
            (txq[c].size() > 0 && bus.tx_data[8*c +: 8] !== txq[c][0]))
          $display("FAIL rand_tx n=%0d ch=%0d got v=%b %h want v=%b %h", n, c, bus.tx_valid[c],
                   bus.tx_data[8*c +: 8], txq[c].size() > 0, (txq[c].size() > 0) ? txq[c][0] : 8'h00);
        else pass_cnt++;
      end
    end
    bus.tx_ready = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_read();
    test_rx_full_popthrough();
    test_irq();
    test_decode();
    test_stall_counters();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
